// File: rtl/mips_pkg.sv
// Shared decode constants for the MIPS ID stage: opcodes, funct codes, ALU/PC-source codes,
// and the EX/M/WB control payload layouts.
package mips_pkg;

    localparam int unsigned NB_DATA  = 32;
    localparam int unsigned NB_REG   = 5;
    localparam int unsigned NB_ADDR  = 10;
    localparam int unsigned NB_OP    = 6;
    localparam int unsigned NB_FUNCT = 6;
    localparam int unsigned NB_IMM   = 16;
    localparam int unsigned N_REGS   = 32;

    localparam logic [NB_OP-1:0] OP_RTYPE = 6'h00;
    localparam logic [NB_OP-1:0] OP_J     = 6'h02;
    localparam logic [NB_OP-1:0] OP_JAL   = 6'h03;
    localparam logic [NB_OP-1:0] OP_BEQ   = 6'h04;
    localparam logic [NB_OP-1:0] OP_BNE   = 6'h05;
    localparam logic [NB_OP-1:0] OP_ADDI  = 6'h08;
    localparam logic [NB_OP-1:0] OP_ADDIU = 6'h09;
    localparam logic [NB_OP-1:0] OP_SLTI  = 6'h0A;
    localparam logic [NB_OP-1:0] OP_SLTIU = 6'h0B;
    localparam logic [NB_OP-1:0] OP_ANDI  = 6'h0C;
    localparam logic [NB_OP-1:0] OP_ORI   = 6'h0D;
    localparam logic [NB_OP-1:0] OP_XORI  = 6'h0E;
    localparam logic [NB_OP-1:0] OP_LUI   = 6'h0F;
    localparam logic [NB_OP-1:0] OP_LB    = 6'h20;
    localparam logic [NB_OP-1:0] OP_LH    = 6'h21;
    localparam logic [NB_OP-1:0] OP_LW    = 6'h23;
    localparam logic [NB_OP-1:0] OP_LBU   = 6'h24;
    localparam logic [NB_OP-1:0] OP_LHU   = 6'h25;
    localparam logic [NB_OP-1:0] OP_LWU   = 6'h27;
    localparam logic [NB_OP-1:0] OP_SB    = 6'h28;
    localparam logic [NB_OP-1:0] OP_SH    = 6'h29;
    localparam logic [NB_OP-1:0] OP_SW    = 6'h2B;
    localparam logic [NB_OP-1:0] OP_HALT  = 6'h3F;

    localparam logic [NB_FUNCT-1:0] FN_SLL  = 6'h00;
    localparam logic [NB_FUNCT-1:0] FN_SRL  = 6'h02;
    localparam logic [NB_FUNCT-1:0] FN_SRA  = 6'h03;
    localparam logic [NB_FUNCT-1:0] FN_JR   = 6'h08;
    localparam logic [NB_FUNCT-1:0] FN_JALR = 6'h09;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_RTYPE = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;
    localparam logic [2:0] ALU_SUB   = 3'b111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Field order fixes the bit positions of o_EX_control / o_M_control / o_WB_control.
    typedef struct packed {
        logic [1:0] reg_dst;
        logic       alu_a;
        logic       alu_b;
        logic [2:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       sign_ext;
        logic [1:0] size;
        logic       pad;
    } m_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctrl_t;

    function automatic m_ctrl_t f_mem_ctrl(input logic rd, input logic wr, input logic sx,
                                           input logic [1:0] sz);
        return '{mem_read: rd, mem_write: wr, sign_ext: sx, size: sz, pad: 1'b0};
    endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/ID, write-back, hazard and ID/EX signal bundle of the decode stage.
interface id_decode_stage_if;
    import mips_pkg::*;

    logic [NB_DATA-1:0]  i_instruction, i_pc, i_data_rw, i_data_forward_EX_MEM;
    logic [NB_REG-1:0]   i_write_register, i_addr_debug_unit, i_EX_write_register_usage, i_EX_rt;
    logic                i_reg_write, i_ctrl_read_debug_reg, i_ID_EX_mem_read, i_EX_reg_write;
    logic                i_forward_A, i_forward_B;

    logic [NB_REG-1:0]   o_rs, o_rt, o_rd, o_shamt;
    logic [NB_FUNCT-1:0] o_function;
    logic [NB_DATA-1:0]  o_data_ra, o_data_rb, o_inm_ext, o_data_reg_debug_unit;
    logic [1:0]          o_pc_src;
    logic                o_branch_or_jump, o_pc_write, o_IF_ID_write, o_halt;
    logic [NB_ADDR-1:0]  o_addr_register, o_addr_branch, o_addr_jump;
    logic [6:0]          o_EX_control;
    logic [5:0]          o_M_control;
    logic [2:0]          o_WB_control;

    modport master (
        output i_instruction, i_pc, i_data_rw, i_data_forward_EX_MEM, i_write_register,
               i_addr_debug_unit, i_EX_write_register_usage, i_EX_rt, i_reg_write,
               i_ctrl_read_debug_reg, i_ID_EX_mem_read, i_EX_reg_write, i_forward_A, i_forward_B,
        input  o_rs, o_rt, o_rd, o_shamt, o_function, o_data_ra, o_data_rb, o_inm_ext,
               o_data_reg_debug_unit, o_pc_src, o_branch_or_jump, o_pc_write, o_IF_ID_write,
               o_halt, o_addr_register, o_addr_branch, o_addr_jump, o_EX_control, o_M_control,
               o_WB_control
    );

    modport slave (
        input  i_instruction, i_pc, i_data_rw, i_data_forward_EX_MEM, i_write_register,
               i_addr_debug_unit, i_EX_write_register_usage, i_EX_rt, i_reg_write,
               i_ctrl_read_debug_reg, i_ID_EX_mem_read, i_EX_reg_write, i_forward_A, i_forward_B,
        output o_rs, o_rt, o_rd, o_shamt, o_function, o_data_ra, o_data_rb, o_inm_ext,
               o_data_reg_debug_unit, o_pc_src, o_branch_or_jump, o_pc_write, o_IF_ID_write,
               o_halt, o_addr_register, o_addr_branch, o_addr_jump, o_EX_control, o_M_control,
               o_WB_control
    );

endinterface

// File: rtl/register_file.sv
// 32x32 register file: one write port, three combinational read ports, $0 hard-wired to zero.
// REGFILE_BYPASS_EN: reads of the register being written this cycle return the write data.
module register_file
    import mips_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_we,
    input  logic [NB_REG-1:0]  i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_REG-1:0]  i_addr_a,
    input  logic [NB_REG-1:0]  i_addr_b,
    input  logic [NB_REG-1:0]  i_addr_dbg,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_DATA-1:0] o_data_dbg
);

    logic [NB_DATA-1:0] r_regs [N_REGS];
    logic               w_we_valid;

    assign w_we_valid = i_we && (i_waddr != '0);

    // $0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
        end else if (w_we_valid) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_data_a   = r_regs[i_addr_a];
        o_data_b   = r_regs[i_addr_b];
        o_data_dbg = r_regs[i_addr_dbg];
`ifdef REGFILE_BYPASS_EN
        if (w_we_valid && (i_addr_a == i_waddr))   o_data_a   = i_wdata;
        if (w_we_valid && (i_addr_b == i_waddr))   o_data_b   = i_wdata;
        if (w_we_valid && (i_addr_dbg == i_waddr)) o_data_dbg = i_wdata;
`else
        if (w_we_valid && (i_addr_a == i_waddr) && (i_addr_b == i_waddr)) o_data_a = r_regs[i_addr_a];
`endif
    end

endmodule

// File: rtl/id_decode_stage.sv
// MIPS ID stage: field split, register file, immediate extension, control decode, branch
// resolution and hazard stalls. Optional REGFILE_BYPASS_EN enables write-to-read bypass.
module id_decode_stage
    import mips_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    id_decode_stage_if.slave  bus
);

    logic [NB_OP-1:0]    w_opcode;
    logic [NB_FUNCT-1:0] w_funct;
    logic [NB_IMM-1:0]   w_imm;
    logic [NB_REG-1:0]   w_rs, w_rt;
    logic [NB_DATA-1:0]  w_data_ra, w_data_rb, w_data_dbg, w_inm_ext, w_op_a, w_op_b;
    ex_ctrl_t            w_ex;
    m_ctrl_t             w_m;
    wb_ctrl_t            w_wb;
    logic w_is_beq, w_is_bne, w_is_jump, w_is_jreg, w_is_halt, w_taken;
    logic w_load_use, w_branch_hz, w_stall;

    assign w_opcode = bus.i_instruction[31:26];
    assign w_rs     = bus.i_instruction[25:21];
    assign w_rt     = bus.i_instruction[20:16];
    assign w_funct  = bus.i_instruction[5:0];
    assign w_imm    = bus.i_instruction[15:0];

    assign bus.o_rs       = w_rs;
    assign bus.o_rt       = w_rt;
    assign bus.o_rd       = bus.i_instruction[15:11];
    assign bus.o_shamt    = bus.i_instruction[10:6];
    assign bus.o_function = w_funct;

    register_file u_regfile (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_we       (bus.i_reg_write),
        .i_waddr    (bus.i_write_register),
        .i_wdata    (bus.i_data_rw),
        .i_addr_a   (w_rs),
        .i_addr_b   (w_rt),
        .i_addr_dbg (bus.i_addr_debug_unit),
        .o_data_a   (w_data_ra),
        .o_data_b   (w_data_rb),
        .o_data_dbg (w_data_dbg)
    );

    assign bus.o_data_ra             = w_data_ra;
    assign bus.o_data_rb             = w_data_rb;
    assign bus.o_data_reg_debug_unit = bus.i_ctrl_read_debug_reg ? w_data_dbg : '0;

    // Logical immediates zero-extend, LUI shifts up, everything else sign-extends.
    always_comb begin
        case (w_opcode)
            OP_ANDI, OP_ORI, OP_XORI: w_inm_ext = {16'h0000, w_imm};
            OP_LUI:                   w_inm_ext = {w_imm, 16'h0000};
            default:                  w_inm_ext = {{16{w_imm[15]}}, w_imm};
        endcase
    end
    assign bus.o_inm_ext = w_inm_ext;

    // Main control decode; unknown opcodes leave every control at zero (NOP).
    always_comb begin
        w_ex = '0; w_m = '0; w_wb = '0;
        w_is_beq = 1'b0; w_is_bne = 1'b0; w_is_jump = 1'b0; w_is_jreg = 1'b0; w_is_halt = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_ex.reg_dst = DST_RD;
                case (w_funct)
                    FN_JR:   begin w_is_jreg = 1'b1; w_ex.reg_dst = DST_RT; end
                    FN_JALR: begin w_is_jreg = 1'b1; w_wb.reg_write = 1'b1; w_wb.link = 1'b1; end
                    default: begin
                        w_ex.alu_a      = (w_funct == FN_SLL) || (w_funct == FN_SRL) || (w_funct == FN_SRA);
                        w_ex.alu_op     = ALU_RTYPE;
                        w_wb.reg_write  = 1'b1;
                    end
                endcase
            end
            OP_J:   w_is_jump = 1'b1;
            OP_JAL: begin
                w_is_jump = 1'b1; w_ex.reg_dst = DST_RA; w_wb.reg_write = 1'b1; w_wb.link = 1'b1;
            end
            OP_BEQ: begin w_is_beq = 1'b1; w_ex.alu_op = ALU_SUB; end
            OP_BNE: begin w_is_bne = 1'b1; w_ex.alu_op = ALU_SUB; end
            OP_ADDI, OP_ADDIU: begin w_ex.alu_b = 1'b1; w_ex.alu_op = ALU_ADD; w_wb.reg_write = 1'b1; end
            OP_SLTI, OP_SLTIU: begin w_ex.alu_b = 1'b1; w_ex.alu_op = ALU_SLT; w_wb.reg_write = 1'b1; end
            OP_ANDI: begin w_ex.alu_b = 1'b1; w_ex.alu_op = ALU_AND; w_wb.reg_write = 1'b1; end
            OP_ORI:  begin w_ex.alu_b = 1'b1; w_ex.alu_op = ALU_OR;  w_wb.reg_write = 1'b1; end
            OP_XORI: begin w_ex.alu_b = 1'b1; w_ex.alu_op = ALU_XOR; w_wb.reg_write = 1'b1; end
            OP_LUI:  begin w_ex.alu_b = 1'b1; w_ex.alu_op = ALU_LUI; w_wb.reg_write = 1'b1; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                w_ex.alu_b = 1'b1;
                w_m = f_mem_ctrl(1'b1, 1'b0, !w_opcode[2],
                                 (w_opcode[1:0] == 2'b00) ? SIZE_BYTE :
                                 (w_opcode[1:0] == 2'b01) ? SIZE_HALF : SIZE_WORD);
                w_wb.reg_write = 1'b1; w_wb.mem_to_reg = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                w_ex.alu_b = 1'b1;
                w_m = f_mem_ctrl(1'b0, 1'b1, 1'b1,
                                 (w_opcode == OP_SB) ? SIZE_BYTE :
                                 (w_opcode == OP_SH) ? SIZE_HALF : SIZE_WORD);
            end
            OP_HALT: w_is_halt = 1'b1;
            default: ;
        endcase
    end

    // Branch operands may come from EX/MEM forwarding instead of the register file.
    assign w_op_a  = bus.i_forward_A ? bus.i_data_forward_EX_MEM : w_data_ra;
    assign w_op_b  = bus.i_forward_B ? bus.i_data_forward_EX_MEM : w_data_rb;
    assign w_taken = (w_is_beq && (w_op_a == w_op_b)) || (w_is_bne && (w_op_a != w_op_b));

    assign bus.o_addr_branch   = bus.i_pc[NB_ADDR-1:0] + w_inm_ext[NB_ADDR-1:0];
    assign bus.o_addr_jump     = bus.i_instruction[NB_ADDR-1:0];
    assign bus.o_addr_register = w_op_a[NB_ADDR-1:0];

    assign w_load_use  = bus.i_ID_EX_mem_read && (bus.i_EX_rt != '0) &&
                         ((bus.i_EX_rt == w_rs) || (bus.i_EX_rt == w_rt));
    assign w_branch_hz = bus.i_EX_reg_write && (bus.i_EX_write_register_usage != '0) &&
                         (((w_is_beq || w_is_bne) && ((bus.i_EX_write_register_usage == w_rs) ||
                                                      (bus.i_EX_write_register_usage == w_rt))) ||
                          (w_is_jreg && (bus.i_EX_write_register_usage == w_rs)));
    assign w_stall     = w_load_use || w_branch_hz;

    // Control outputs: zero under reset, bubble on stall, otherwise decoded controls.
    always_comb begin
        bus.o_pc_src = PC_SEQ; bus.o_branch_or_jump = 1'b0;
        bus.o_pc_write = 1'b0; bus.o_IF_ID_write = 1'b0; bus.o_halt = 1'b0;
        bus.o_EX_control = '0; bus.o_M_control = '0; bus.o_WB_control = '0;
        if (i_reset) begin
            bus.o_halt = w_is_halt;
            if (!w_stall) begin
                bus.o_pc_write = 1'b1; bus.o_IF_ID_write = 1'b1;
                bus.o_EX_control = w_ex; bus.o_M_control = w_m; bus.o_WB_control = w_wb;
                if (w_is_jump)      begin bus.o_pc_src = PC_JUMP;   bus.o_branch_or_jump = 1'b1; end
                else if (w_is_jreg) begin bus.o_pc_src = PC_REG;    bus.o_branch_or_jump = 1'b1; end
                else if (w_taken)   begin bus.o_pc_src = PC_BRANCH; bus.o_branch_or_jump = 1'b1; end
            end
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed, table-driven bench for id_decode_stage with hand-computed expectations.
module tb_id_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_decode_stage_if bus();
    id_decode_stage u_dut (.i_clock(clk), .i_reset(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0]  rs, rt;
        logic [31:0] ra, rb, inm;
        logic [9:0]  abr, ajp;
        logic [1:0]  psrc;
        logic        boj, pcw, ifid;
        logic [6:0]  ex;
        logic [5:0]  m;
        logic [2:0]  wb;
        logic        halt;
    } obs_t;

    typedef struct {
        string       nm;
        logic [31:0] ins, pc;
        logic        mr;
        logic [4:0]  ert;
        logic        erw;
        logic [4:0]  edst;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                       input logic mr, input logic [4:0] ert, input logic erw, input logic [4:0] edst,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [31:0] inm, input logic [9:0] abr,
                       input logic [9:0] ajp, input logic [1:0] psrc, input logic boj,
                       input logic pcw, input logic [6:0] ex, input logic [5:0] m,
                       input logic [2:0] wb, input logic halt);
        vec_t v;
        v.nm = nm; v.ins = ins; v.pc = pc; v.mr = mr; v.ert = ert; v.erw = erw; v.edst = edst;
        v.exp = '{rs, rt, ra, rb, inm, abr, ajp, psrc, boj, pcw, pcw, ex, m, wb, halt};
        vecs.push_back(v);
    endtask

    function automatic obs_t sample();
        return '{bus.o_rs, bus.o_rt, bus.o_data_ra, bus.o_data_rb, bus.o_inm_ext, bus.o_addr_branch,
                 bus.o_addr_jump, bus.o_pc_src, bus.o_branch_or_jump, bus.o_pc_write,
                 bus.o_IF_ID_write, bus.o_EX_control, bus.o_M_control, bus.o_WB_control, bus.o_halt};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] ins, input logic [31:0] pc, input logic mr,
                          input logic [4:0] ert, input logic erw, input logic [4:0] edst,
                          input logic fa, input logic fb, input logic [31:0] fwd);
        bus.i_instruction = ins; bus.i_pc = pc; bus.i_ID_EX_mem_read = mr; bus.i_EX_rt = ert;
        bus.i_EX_reg_write = erw; bus.i_EX_write_register_usage = edst;
        bus.i_forward_A = fa; bus.i_forward_B = fb; bus.i_data_forward_EX_MEM = fwd;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.i_reg_write = 1'b1; bus.i_write_register = addr; bus.i_data_rw = data;
        @(negedge clk);
        bus.i_reg_write = 1'b0;
    endtask

    task automatic dbg_check(input string nm, input logic [4:0] idx, input logic [31:0] exp);
        bus.i_ctrl_read_debug_reg = 1'b1; bus.i_addr_debug_unit = idx;
        #1;
        check(nm, bus.o_data_reg_debug_unit, exp);
        bus.i_ctrl_read_debug_reg = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_byp;
        rst_n = 1'b0;
        bus.i_reg_write = 1'b0; bus.i_write_register = 5'd0; bus.i_data_rw = 32'd0;
        bus.i_ctrl_read_debug_reg = 1'b0; bus.i_addr_debug_unit = 5'd0;
        set_in(32'h8C470000, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        #2;
        check("rst_pc_write", 32'(bus.o_pc_write), 32'd0);
        check("rst_ifid_write", 32'(bus.o_IF_ID_write), 32'd0);
        check("rst_ctrl", 32'({bus.o_EX_control, bus.o_M_control, bus.o_WB_control}), 32'd0);
        set_in(32'hFC000000, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        #1;
        check("rst_halt", 32'(bus.o_halt), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 32; i++) dbg_check($sformatf("dbg_reset_r%0d", i), 5'(i), 32'd0);

        wb_write(5'd5, 32'h0000CAFE);
        dbg_check("dbg_r5", 5'd5, 32'h0000CAFE);
        bus.i_addr_debug_unit = 5'd5; #1;
        check("dbg_disabled", bus.o_data_reg_debug_unit, 32'd0);
        wb_write(5'd0, 32'hFFFFFFFF);
        dbg_check("dbg_r0_wired_zero", 5'd0, 32'd0);

        // Read of a register during its own write cycle depends on the bypass option.
        @(negedge clk);
        bus.i_reg_write = 1'b1; bus.i_write_register = 5'd9; bus.i_data_rw = 32'h00000077;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h00000077;
`else
        exp_byp = 32'd0;
`endif
        dbg_check("dbg_same_cycle_r9", 5'd9, exp_byp);
        @(negedge clk); bus.i_reg_write = 1'b0;
        dbg_check("dbg_r9_after", 5'd9, 32'h00000077);

        wb_write(5'd1, 32'd3);
        wb_write(5'd2, 32'd3);

        //   name         instr         pc     mr   ert   erw   edst   rs    rt    ra      rb      inm           abr     ajp     psrc  boj  pcw  ex          m          wb      halt
        add("lw",       32'h8C470000, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd2,5'd7, 32'd3,32'd0, 32'h00000000, 10'h000,10'h000, 2'b00,1'b0,1'b1, 7'b0001000,6'b101110,3'b110,1'b0);
        add("add_lduse",32'h00222021, 32'd0, 1'b1,5'd1,1'b0,5'd0, 5'd1,5'd2, 32'd3,32'd3, 32'h00002021, 10'h021,10'h021, 2'b00,1'b0,1'b0, 7'b0000000,6'b000000,3'b000,1'b0);
        add("add_ert0", 32'h00222021, 32'd0, 1'b1,5'd0,1'b0,5'd0, 5'd1,5'd2, 32'd3,32'd3, 32'h00002021, 10'h021,10'h021, 2'b00,1'b0,1'b1, 7'b0100001,6'b000000,3'b100,1'b0);
        add("sw",       32'hAC8C0000, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd4,5'd12,32'd0,32'd0, 32'h00000000, 10'h000,10'h000, 2'b00,1'b0,1'b1, 7'b0001000,6'b011110,3'b000,1'b0);
        add("j",        32'h08000001, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd0,5'd0, 32'd0,32'd0, 32'h00000001, 10'h001,10'h001, 2'b10,1'b1,1'b1, 7'b0000000,6'b000000,3'b000,1'b0);
        add("beq_taken",32'h1022FFFE, 32'd10,1'b0,5'd0,1'b0,5'd0, 5'd1,5'd2, 32'd3,32'd3, 32'hFFFFFFFE, 10'h008,10'h3FE, 2'b01,1'b1,1'b1, 7'b0000111,6'b000000,3'b000,1'b0);
        add("bne_nt",   32'h1422FFFE, 32'd10,1'b0,5'd0,1'b0,5'd0, 5'd1,5'd2, 32'd3,32'd3, 32'hFFFFFFFE, 10'h008,10'h3FE, 2'b00,1'b0,1'b1, 7'b0000111,6'b000000,3'b000,1'b0);
        add("beq_stall",32'h1022FFFE, 32'd10,1'b0,5'd0,1'b1,5'd1, 5'd1,5'd2, 32'd3,32'd3, 32'hFFFFFFFE, 10'h008,10'h3FE, 2'b00,1'b0,1'b0, 7'b0000000,6'b000000,3'b000,1'b0);
        add("beq_dst0", 32'h1022FFFE, 32'd10,1'b0,5'd0,1'b1,5'd0, 5'd1,5'd2, 32'd3,32'd3, 32'hFFFFFFFE, 10'h008,10'h3FE, 2'b01,1'b1,1'b1, 7'b0000111,6'b000000,3'b000,1'b0);
        add("halt",     32'hFC000000, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd0,5'd0, 32'd0,32'd0, 32'h00000000, 10'h000,10'h000, 2'b00,1'b0,1'b1, 7'b0000000,6'b000000,3'b000,1'b1);
        add("unknown",  32'hF8000000, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd0,5'd0, 32'd0,32'd0, 32'h00000000, 10'h000,10'h000, 2'b00,1'b0,1'b1, 7'b0000000,6'b000000,3'b000,1'b0);
        add("ori",      32'h34238001, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd1,5'd3, 32'd3,32'd0, 32'h00008001, 10'h001,10'h001, 2'b00,1'b0,1'b1, 7'b0001011,6'b000000,3'b100,1'b0);
        add("lui",      32'h3C031234, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd0,5'd3, 32'd0,32'd0, 32'h12340000, 10'h000,10'h234, 2'b00,1'b0,1'b1, 7'b0001101,6'b000000,3'b100,1'b0);
        add("jal",      32'h0C000001, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd0,5'd0, 32'd0,32'd0, 32'h00000001, 10'h001,10'h001, 2'b10,1'b1,1'b1, 7'b1000000,6'b000000,3'b101,1'b0);
        add("jr",       32'h00200008, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd1,5'd0, 32'd3,32'd0, 32'h00000008, 10'h008,10'h008, 2'b11,1'b1,1'b1, 7'b0000000,6'b000000,3'b000,1'b0);
        add("jalr",     32'h0020F809, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd1,5'd0, 32'd3,32'd0, 32'hFFFFF809, 10'h009,10'h009, 2'b11,1'b1,1'b1, 7'b0100000,6'b000000,3'b101,1'b0);
        add("sll",      32'h00011100, 32'd0, 1'b0,5'd0,1'b0,5'd0, 5'd0,5'd1, 32'd0,32'd3, 32'h00001100, 10'h100,10'h100, 2'b00,1'b0,1'b1, 7'b0110001,6'b000000,3'b100,1'b0);
        add("jr_stall", 32'h00200008, 32'd0, 1'b0,5'd0,1'b1,5'd1, 5'd1,5'd0, 32'd3,32'd0, 32'h00000008, 10'h008,10'h008, 2'b00,1'b0,1'b0, 7'b0000000,6'b000000,3'b000,1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            set_in(vecs[i].ins, vecs[i].pc, vecs[i].mr, vecs[i].ert, vecs[i].erw, vecs[i].edst,
                   1'b0, 1'b0, 32'd0);
            #2;
            check_obs(vecs[i].nm, sample(), vecs[i].exp);
        end

        // Branch operand mismatch, then forwarding on A and on B.
        wb_write(5'd2, 32'd4);
        set_in(32'h1022FFFE, 32'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0); #2;
        check("beq_ne_src", 32'(bus.o_pc_src), 32'd0);
        check("beq_ne_boj", 32'(bus.o_branch_or_jump), 32'd0);
        set_in(32'h1022FFFE, 32'd10, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 32'd4); #2;
        check("beq_fwdA_src", 32'(bus.o_pc_src), 32'd1);
        check("beq_fwdA_addr", 32'(bus.o_addr_branch), 32'd8);
        set_in(32'h1422FFFE, 32'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0); #2;
        check("bne_taken_src", 32'(bus.o_pc_src), 32'd1);
        set_in(32'h1422FFFE, 32'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'd3); #2;
        check("bne_fwdB_src", 32'(bus.o_pc_src), 32'd0);
        set_in(32'h1022FFFE, 32'd10, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 32'd0); #2;
        check("beq_stall_rt", 32'(bus.o_pc_write), 32'd0);
        set_in(32'h00222021, 32'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0); #2;
        check("lduse_rt", 32'(bus.o_IF_ID_write), 32'd0);

        // JR target from register file and from forwarded data.
        set_in(32'h00200008, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0); #2;
        check("jr_addr_reg", 32'(bus.o_addr_register), 32'd3);
        set_in(32'h00200008, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h00000155); #2;
        check("jr_addr_fwd", 32'(bus.o_addr_register), 32'h155);
        check("jr_fwd_src", 32'(bus.o_pc_src), 32'd3);

        // A second reset pulse clears previously written registers.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        dbg_check("dbg_r5_rereset", 5'd5, 32'd0);
        dbg_check("dbg_r1_rereset", 5'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
